// File: rtl/cs_pkg.sv
// Shared CheckSum (CS) definitions: data/result field widths, the packed word geometry
// and the byte packer state encoding, reused by the packer and by CS benches.
package cs_pkg;

   localparam int WIDTH_DATA_1   = 384;
   localparam int WIDTH_DATA_2   = 128;
   localparam int WIDTH_RESULT_1 = 32;
   localparam int WIDTH_RESULT_2 = 16;

   localparam int BYTE_W     = 8;
   localparam int WORD_W     = WIDTH_DATA_1 + WIDTH_DATA_2;
   localparam int WORD_BYTES = WORD_W / BYTE_W;
   localparam int LEN_W      = $clog2(WORD_BYTES) + 1;

   typedef logic [WORD_W-1:0] cs_word_t;
   typedef logic [LEN_W-1:0]  cs_len_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } packer_state_e;

endpackage

// File: rtl/cs_byte_packer_if.sv
// Byte stream in, CS word out. The master side feeds bytes and reports CS completion;
// the slave side is the packer.
interface cs_byte_packer_if;
   import cs_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [BYTE_W-1:0]   s_data;
   logic                s_last;
   logic                m_valid;
   cs_word_t            m_data;
   cs_len_t             m_len;
   logic                cs_done;

   modport master (
      output s_valid, s_data, s_last, cs_done,
      input  s_ready, m_valid, m_data, m_len
   );

   modport slave (
      input  s_valid, s_data, s_last, cs_done,
      output s_ready, m_valid, m_data, m_len
   );

endinterface

// File: rtl/cs_byte_packer.sv
// Packs up to 64 stream bytes MSB-first into one 512-bit CS word, pulses m_valid once,
// then holds the word until CS signals completion. All outputs come straight from flops.
module cs_byte_packer
   import cs_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   cs_byte_packer_if.slave  bus
);

   packer_state_e state_q, state_d;
   cs_len_t       cnt_q, cnt_d;
   cs_word_t      data_q, data_d;
   logic          s_ready_q, s_ready_d;
   logic          m_valid_q, m_valid_d;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;

      unique case (state_q)
         IDLE, FILL: begin
            // s_ready_q is only set in IDLE/FILL, so it doubles as the accept qualifier.
            if (bus.s_valid && s_ready_q) begin
               // Byte k lands at bit (63-k)*8, i.e. {~k, 3'b000}.
               data_d[{~cnt_q[5:0], 3'b000} +: BYTE_W] = bus.s_data;
               cnt_d   = cnt_q + cs_len_t'(1);
               state_d = (bus.s_last || cnt_q == cs_len_t'(WORD_BYTES - 1)) ? ISSUE : FILL;
            end
         end
         ISSUE, WAIT: begin
            if (bus.cs_done) begin
               state_d = IDLE;
               cnt_d   = '0;
               data_d  = '0;
            end else begin
               state_d = WAIT;
            end
         end
      endcase

      s_ready_d = (state_d == IDLE) || (state_d == FILL);
      m_valid_d = (state_d == ISSUE);
   end

   // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign bus.s_ready = s_ready_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = data_q;
   assign bus.m_len   = cnt_q;

endmodule

// File: tb/tb_cs_byte_packer.sv
// Directed bench for cs_byte_packer: full, short, overlong frames, delayed and early
// cs_done, spurious cs_done and mid-frame resets, against hand-computed words.
module tb_cs_byte_packer;
   import cs_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   int   pulse_cnt = 0;

   cs_byte_packer_if bus ();

   cs_byte_packer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.m_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, expected $finish)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one byte and return one cycle after the edge that accepted it.
   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      while (bus.s_ready !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) check("send_ready_timeout", bus.s_ready, 1);
      step();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic release_word();
      bus.cs_done = 1'b1;
      step();
      bus.cs_done = 1'b0;
   endtask

   function automatic logic [511:0] seq_word(input logic [7:0] first, input int n);
      logic [511:0] w = '0;
      for (int k = 0; k < n; k++) w[511-8*k -: 8] = first + 8'(k);
      return w;
   endfunction

   logic [511:0] exp_w;
   logic [511:0] held;

   initial begin
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.cs_done = 1'b0;
      step();
      step();
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_data",  bus.m_data,  0);
      check("rst_m_len",   bus.m_len,   0);
      rst = 1'b0;
      step();
      check("post_rst_s_ready", bus.s_ready, 1);

      // Full 64-byte word 0x00..0x3F.
      for (int i = 0; i < 64; i++) send(8'(i), i == 63);
      exp_w = seq_word(8'h00, 64);
      check("full_m_valid", bus.m_valid, 1);
      check("full_top_byte", bus.m_data[511:504], 8'h00);
      check("full_low_byte", bus.m_data[7:0], 8'h3F);
      check("full_m_data", bus.m_data, exp_w);
      check("full_m_len", bus.m_len, 64);
      check("full_s_ready_issue", bus.s_ready, 0);
      step();
      check("full_m_valid_pulse", bus.m_valid, 0);
      check("full_s_ready_wait", bus.s_ready, 0);
      check("full_hold", bus.m_data, exp_w);
      release_word();
      check("full_release_ready", bus.s_ready, 1);
      check("full_release_clear", bus.m_data, 0);
      check("full_release_len", bus.m_len, 0);

      // Short frame, with cs_done already in the ISSUE cycle.
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b1);
      exp_w = '0;
      exp_w[511:488] = 24'hAABBCC;
      check("short_m_valid", bus.m_valid, 1);
      check("short_m_data", bus.m_data, exp_w);
      check("short_m_len", bus.m_len, 3);
      release_word();
      check("early_done_s_ready", bus.s_ready, 1);
      check("early_done_m_valid", bus.m_valid, 0);

      // 70 bytes with s_last only on the last: splits into 64 + 6.
      for (int i = 0; i < 64; i++) send(8'(8'h80 + i), 1'b0);
      check("long1_m_valid", bus.m_valid, 1);
      check("long1_m_len", bus.m_len, 64);
      check("long1_m_data", bus.m_data, seq_word(8'h80, 64));
      step();
      release_word();
      for (int i = 64; i < 70; i++) send(8'(8'h80 + i), i == 69);
      check("long2_m_valid", bus.m_valid, 1);
      check("long2_m_len", bus.m_len, 6);
      check("long2_m_data", bus.m_data, seq_word(8'hC0, 6));
      release_word();

      // cs_done 20 cycles late while upstream keeps offering a byte.
      send(8'h5A, 1'b0);
      send(8'hA5, 1'b1);
      held = bus.m_data;
      exp_w = '0;
      exp_w[511:496] = 16'h5AA5;
      check("delay_m_data", held, exp_w);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h77;
      bus.s_last  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check("delay_s_ready", bus.s_ready, 0);
         check("delay_hold", bus.m_data, held);
      end
      release_word();
      check("delay_ready_after_done", bus.s_ready, 1);
      step();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      exp_w = '0;
      exp_w[511:504] = 8'h77;
      check("delay_next_m_valid", bus.m_valid, 1);
      check("delay_next_m_data", bus.m_data, exp_w);
      check("delay_next_m_len", bus.m_len, 1);
      release_word();

      // Spurious cs_done during FILL.
      send(8'h01, 1'b0);
      release_word();
      check("spurious_s_ready", bus.s_ready, 1);
      check("spurious_m_len", bus.m_len, 1);
      send(8'h02, 1'b1);
      exp_w = '0;
      exp_w[511:496] = 16'h0102;
      check("spurious_m_data", bus.m_data, exp_w);
      check("spurious_m_len2", bus.m_len, 2);
      release_word();

      // Reset mid-FILL after 30 bytes.
      for (int i = 0; i < 30; i++) send(8'(8'h20 + i), 1'b0);
      rst = 1'b1;
      step();
      check("rst_fill_s_ready", bus.s_ready, 0);
      check("rst_fill_m_valid", bus.m_valid, 0);
      check("rst_fill_m_data", bus.m_data, 0);
      check("rst_fill_m_len", bus.m_len, 0);
      rst = 1'b0;
      step();
      check("rst_fill_ready_back", bus.s_ready, 1);

      // Reset while in WAIT.
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      step();
      rst = 1'b1;
      step();
      check("rst_wait_m_data", bus.m_data, 0);
      check("rst_wait_m_len", bus.m_len, 0);
      check("rst_wait_m_valid", bus.m_valid, 0);
      rst = 1'b0;
      step();
      send(8'h11, 1'b1);
      exp_w = '0;
      exp_w[511:504] = 8'h11;
      check("after_rst_m_data", bus.m_data, exp_w);
      check("after_rst_m_len", bus.m_len, 1);
      release_word();
      step();
      step();
      check("pulse_count", 32'(pulse_cnt), 9);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
